// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
package fifo_pkg;
  localparam int FIFO_STD     = 0;
  localparam int FIFO_FWFT    = 1;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; the FIFO takes the slave side.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CW = clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// Storage array: synchronous write port, asynchronous read port.
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with separate occupancy counter, threshold flags,
// sticky error flags and standard or first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              full, empty, wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come from the registered count only, never from the requests.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A fresh rejection outranks a clear in the same cycle.
    ovf_d = (bus.wr_en && full)  ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    udf_d = (bus.rd_en && empty) ? 1'b1 : (bus.clr_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign bus.rd_data  = empty ? '0 : mem_rdata;
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_rdata;
        end
      end
      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
